mesh_send_arbiter: RTL and testbench

- Shares one outgoing mesh link (one direction's send_data/send_ready/send_done triple on the tile) between NREQ on-tile requesters, such as the core's send path and a forwarding/route-through path.
- Round-robin grant.
- One word is in flight at a time.
- Sits between the requesters and a single direction of the tile's mesh interface.

---
 rtl/mesh_arb_pkg.sv | 24 ++
 rtl/mesh_send_arbiter_rr_pick.sv | 41 ++++
 rtl/mesh_send_arbiter.sv | 153 +++++++++++++++
 tb/tb_mesh_send_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared types and helpers for the mesh send arbiter.
// Holds the FSM state encoding, the mesh word type and the
// round-robin pointer wrap helper used by the arbiter top.
package mesh_arb_pkg;

    // Upper bound on the number of requesters sharing one link
    localparam int NREQ_MAX = 8;

    // One mesh word as carried on send_data
    typedef logic [31:0] word;

    // Arbiter FSM: wait for a request, drive the link, then force a gap cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Index of the requester after idx, wrapping at n
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/mesh_send_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The request vector is doubled and rotated right by the pointer so that the
// lowest set bit of the rotated window is the first requester at or after
// the pointer; the offset is then added back to recover the real index.
module rr_pick
    import mesh_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         pick_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0] rotated;
    logic [IDXW-1:0] offset;
    logic [IDXW:0]   sum;

    // Rotate, priority-encode the lowest set bit, then undo the rotation
    always_comb begin
        rotated = NREQ'({req_i, req_i} >> ptr_i);
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDXW'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= (IDXW+1)'(NREQ)) begin
            sum = sum - (IDXW+1)'(NREQ);
        end
        idx_o  = sum[IDXW-1:0];
        any_o  = |req_i;
        pick_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mesh_send_arbiter.sv
// Round-robin arbiter sharing one outgoing mesh link between NREQ requesters.
// One word is in flight at a time; every word is followed by a one-cycle gap
// with send_ready low. Optional macro LINK_TIMEOUT_EN adds a SEND watchdog
// that aborts a stuck word after TIMEOUT cycles and raises sticky link_err.
module mesh_send_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      grant,
    output word                  send_data,
    output logic                 send_ready,
    input  logic                 send_done,
    output logic                 link_err
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    word             data_q, data_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] ptr_after;

    logic [NREQ-1:0] pick;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

`ifdef LINK_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    localparam int unusedTimeout = TIMEOUT;
`endif

    // Pointer value that puts the requester after the current owner first
    always_comb begin
        ptr_after = IDXW'(wrap_next(32'(gidx_q), NREQ));
    end

    // Next-state logic for the arbiter FSM and its datapath registers
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        done_d  = '0;
        ptr_d   = ptr_q;
`ifdef LINK_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    data_d  = req_data[32*pick_idx +: 32];
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    state_d = SEND;
`ifdef LINK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SEND: begin
                if (send_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                    state_d = DONE;
                end
`ifdef LINK_TIMEOUT_EN
                else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any word in flight
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            data_q  <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef LINK_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign link_err = err_q;
`else
    assign link_err = 1'b0;
`endif

    assign send_ready = (state_q == SEND);
    assign send_data  = data_q;
    assign grant      = grant_q;
    assign req_done   = done_q;

endmodule

// File: tb/tb_mesh_send_arbiter.sv
// Directed self-checking bench for mesh_send_arbiter (NREQ=4, TIMEOUT=8).
// The watchdog steps are included when LINK_TIMEOUT_EN is defined.
module tb_mesh_send_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic                clk;
    logic                nrst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     req_done;
    logic [NREQ-1:0]     grant;
    logic [31:0]         send_data;
    logic                send_ready;
    logic                send_done;
    logic                link_err;

    int                  checks;
    int                  failures;
    logic                expErr;
    logic [NREQ-1:0]     expGrant;
    logic [NREQ-1:0]     holdValid;

    mesh_send_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_done   (req_done),
        .grant      (grant),
        .send_data  (send_data),
        .send_ready (send_ready),
        .send_done  (send_done),
        .link_err   (link_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the requester valids and send_done, then advance past one rising edge
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic done);
        req_valid = valid;
        send_done = done;
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse starting just after a rising edge
    task automatic applyReset();
        nrst = 1'b0;
        #4;
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        checks    = 0;
        failures  = 0;
        expErr    = 1'b0;
        expGrant  = '0;
        holdValid = '0;
        nrst      = 1'b1;
        req_valid = '0;
        send_done = 1'b0;
        req_data  = '0;

        // Asynchronous reset state
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(send_ready), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_done", 32'(req_done), 32'd0);
        checkOutput("rst_data", send_data, 32'd0);
        checkOutput("rst_err", 32'(link_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Single request on requester 2
        req_data[2*32 +: 32] = 32'hDEADBEEF;
        applyStimulus(4'b0100, 1'b0);
        checkOutput("single_ready", 32'(send_ready), 32'd1);
        checkOutput("single_data", send_data, 32'hDEADBEEF);
        checkOutput("single_grant", 32'(grant), 32'h4);
        checkOutput("single_nodone", 32'(req_done), 32'd0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("single_wait_ready", 32'(send_ready), 32'd1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_gap_ready", 32'(send_ready), 32'd0);
        checkOutput("single_gap_grant", 32'(grant), 32'd0);
        checkOutput("single_reqdone", 32'(req_done), 32'h4);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_idle_done", 32'(req_done), 32'd0);
        checkOutput("single_idle_ready", 32'(send_ready), 32'd0);

        // All four requesting with immediate send_done: order 0,1,2,3,0
        applyReset();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*32 +: 32] = 32'h10 + 32'(i);
        end
        for (int w = 0; w < 5; w++) begin
            expGrant = 4'b0001 << (w % 4);
            applyStimulus(4'b1111, 1'b1);
            checkOutput("rr_grant", 32'(grant), 32'(expGrant));
            checkOutput("rr_data", send_data, 32'h10 + 32'(w % 4));
            checkOutput("rr_ready", 32'(send_ready), 32'd1);
            applyStimulus(4'b1111, 1'b1);
            checkOutput("rr_reqdone", 32'(req_done), 32'(expGrant));
            checkOutput("rr_gap_ready", 32'(send_ready), 32'd0);
            applyStimulus(4'b1111, 1'b1);
            checkOutput("rr_idle_done", 32'(req_done), 32'd0);
        end

        // Back-pressure on requester 1 while its data changes and valid drops
        req_data[1*32 +: 32] = 32'h0000AAAA;
        applyStimulus(4'b0010, 1'b0);
        checkOutput("bp_grant", 32'(grant), 32'h2);
        for (int i = 0; i < 20; i++) begin
            req_data[1*32 +: 32] = 32'h12340000 + 32'(i);
            holdValid = (i < 10) ? 4'b0010 : 4'b0000;
            applyStimulus(holdValid, 1'b0);
            checkOutput("bp_ready", 32'(send_ready), 32'd1);
            checkOutput("bp_data", send_data, 32'h0000AAAA);
            checkOutput("bp_grant_hold", 32'(grant), 32'h2);
        end
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_reqdone", 32'(req_done), 32'h2);
        checkOutput("bp_gap_ready", 32'(send_ready), 32'd0);

        // Stray send_done in DONE and then in IDLE
        applyStimulus(4'b0000, 1'b1);
        checkOutput("stray_done_ready", 32'(send_ready), 32'd0);
        checkOutput("stray_done_reqdone", 32'(req_done), 32'd0);
        checkOutput("stray_done_grant", 32'(grant), 32'd0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("stray_idle_ready", 32'(send_ready), 32'd0);
        checkOutput("stray_idle_reqdone", 32'(req_done), 32'd0);
        checkOutput("stray_idle_grant", 32'(grant), 32'd0);

        // Reset mid-SEND, asserted between clock edges
        applyStimulus(4'b1000, 1'b0);
        checkOutput("mid_grant", 32'(grant), 32'h8);
        checkOutput("mid_ready", 32'(send_ready), 32'd1);
        #3;
        nrst = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 32'(send_ready), 32'd0);
        checkOutput("mid_rst_grant", 32'(grant), 32'd0);
        checkOutput("mid_rst_done", 32'(req_done), 32'd0);
        #2;
        nrst = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        checkOutput("post_rst_grant", 32'(grant), 32'h1);
        checkOutput("post_rst_data", send_data, 32'h10);
        checkOutput("post_rst_nodone", 32'(req_done), 32'd0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("post_rst_reqdone", 32'(req_done), 32'h1);
        applyStimulus(4'b0000, 1'b0);

`ifdef LINK_TIMEOUT_EN
        // Watchdog: requester 1 never gets send_done
        applyStimulus(4'b0010, 1'b0);
        checkOutput("to_grant", 32'(grant), 32'h2);
        checkOutput("to_ready_first", 32'(send_ready), 32'd1);
        for (int i = 2; i <= TIMEOUT; i++) begin
            applyStimulus(4'b0010, 1'b0);
            checkOutput("to_ready_hold", 32'(send_ready), 32'd1);
            checkOutput("to_err_low", 32'(link_err), 32'd0);
        end
        applyStimulus(4'b0010, 1'b0);
        expErr = 1'b1;
        checkOutput("to_ready_drop", 32'(send_ready), 32'd0);
        checkOutput("to_err_set", 32'(link_err), 32'(expErr));
        checkOutput("to_no_reqdone", 32'(req_done), 32'd0);
        checkOutput("to_grant_drop", 32'(grant), 32'd0);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("to_idle_done", 32'(req_done), 32'd0);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("to_next_grant", 32'(grant), 32'h4);
        checkOutput("to_err_sticky", 32'(link_err), 32'(expErr));
        applyStimulus(4'b0000, 1'b1);
        checkOutput("to_next_reqdone", 32'(req_done), 32'h4);
        checkOutput("to_err_sticky2", 32'(link_err), 32'(expErr));
        applyStimulus(4'b0000, 1'b0);
`endif

        checkOutput("final_err", 32'(link_err), 32'(expErr));
        checkOutput("final_ready", 32'(send_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
